// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolution stage.
package csa_pkg;

    // Control states of the resolution FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunks needed to cover the W+1 significant bits of the operands.
    function automatic int nchk(input int w, input int chunk);
        return (w + chunk) / chunk;
    endfunction

    // Width of an index able to count n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit ripple adder with carry in and carry out.
module csa_chunk_adder #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // Ripple the carry bit by bit from cin up to cout.
    always_comb begin
        logic [CHUNK:0] carry;
        // NOTE: every output gets a value before the loop so no path leaves it unassigned
        // (no latch), and blocking '=' is required here because each bit reads the carry
        // just written by the previous iteration.
        s        = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[CHUNK];
    end

endmodule

// File: rtl/csa_resolve.sv
// Multi-cycle carry-propagate resolution of a carry-save pair: sum = s + (c << 1).
module csa_resolve
    import csa_pkg::*;
#(
    parameter int W     = 4,
    parameter int CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] sum
);

    localparam int             NCHK   = nchk(W, CHUNK);
    localparam int             KW     = idx_w(NCHK);
    localparam logic [KW-1:0]  K_LAST = KW'(NCHK - 1);

    state_t          state_q;
    state_t          state_d;
    logic [W:0]      a_q;
    logic [W:0]      b_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic [W+1:0]    sum_q;

    logic            accept;
    logic            last;
    int              base;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK-1:0] s_chk;
    logic             c_out;

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (state_q == BUSY) && (k_q == K_LAST);

    // Select chunk k of both operands; bits above W shift in as zero.
    always_comb begin
        base  = int'(k_q) * CHUNK;
        a_chk = CHUNK'(a_q >> base);
        b_chk = CHUNK'(b_q >> base);
    end

    csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .a    (a_chk),
        .b    (b_chk),
        .cin  (carry_q),
        .s    (s_chk),
        .cout (c_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update together on the edge.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, step through chunks in BUSY, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)       state_d = BUSY;
            BUSY:    if (k_q == K_LAST)  state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture and chunk-by-chunk accumulation of the result.
    // A partial top chunk deposits the carry out of bit W straight into sum[W+1];
    // a full top chunk hands it over through c_out instead, so both are merged on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            a_q     <= {1'b0, in_s};
            b_q     <= {in_c, 1'b0};
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
        end else if (state_q == BUSY) begin
            sum_q   <= sum_q
                     | ((W+2)'(s_chk) << base)
                     | (last ? {c_out, {(W+1){1'b0}}} : '0);
            carry_q <= c_out;
            k_q     <= k_q + 1'b1;
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Scoreboard bench for csa_resolve: three parameterisations driven by directed and random pairs.
module tb_csa_resolve;

    localparam int P = 10;
    localparam int NCHK_TAB [3] = '{5, 3, 2};  // W4/C1, W8/C3, W4/C3

    typedef struct {
        logic [9:0] sum;
        longint     t;
    } exp_t;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [9:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv   [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       ov   [3];
    logic [7:0] s_in [3];
    logic [7:0] c_in [3];
    logic [5:0] sum0;
    logic [9:0] sum1;
    logic [5:0] sum2;
    logic [9:0] sumw [3];

    exp_t q [3][$];
    int   tests = 0;
    int   fails = 0;

    always #(P/2) clk = ~clk;

    csa_resolve #(.W(4), .CHUNK(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_s(s_in[0][3:0]), .in_c(c_in[0][3:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0)
    );
    csa_resolve #(.W(8), .CHUNK(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_s(s_in[1]), .in_c(c_in[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1)
    );
    csa_resolve #(.W(4), .CHUNK(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_s(s_in[2][3:0]), .in_c(c_in[2][3:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2)
    );

    assign sumw[0] = {4'b0, sum0};
    assign sumw[1] = sum1;
    assign sumw[2] = {4'b0, sum2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offer one pair to DUT d, wait (bounded) for acceptance and log the expected result.
    task automatic send(input int d, input logic [7:0] s, input logic [7:0] c,
                        input logic [9:0] exp_sum, output longint t_acc);
        int n = 0;
        @(negedge clk);
        iv[d]   = 1'b1;
        s_in[d] = s;
        c_in[d] = c;
        while (!ir[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_acc = 0;
        if (!ir[d]) begin
            check($sformatf("dut%0d_accept_timeout", d), 64'(ir[d]), 64'd1);
            iv[d] = 1'b0;
            return;
        end
        t_acc = longint'($time) + P/2;
        q[d].push_back('{exp_sum, t_acc});
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    // Wait (bounded) until every expected result of DUT d has been presented and consumed.
    task automatic wait_idle(input int d);
        int n = 0;
        while ((q[d].size() != 0 || ov[d]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_drain", d), 64'(q[d].size()), 64'd0);
    endtask

    // Monitor: compare each newly presented result, its latency, and its stability while held.
    logic       seen [3];
    logic [9:0] held [3];
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n || !ov[d]) begin
                seen[d] = 1'b0;
            end else if (!seen[d]) begin
                seen[d] = 1'b1;
                if (q[d].size() == 0) begin
                    check($sformatf("dut%0d_unexpected_output", d), 64'(ov[d]), 64'd0);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    held[d] = e.sum;
                    check($sformatf("dut%0d_sum", d), 64'(sumw[d]), 64'(e.sum));
                    check($sformatf("dut%0d_latency", d),
                          64'((longint'($time) - e.t - P/2) / P), 64'(NCHK_TAB[d]));
                end
            end else begin
                check($sformatf("dut%0d_hold_sum", d), 64'(sumw[d]), 64'(held[d]));
                check($sformatf("dut%0d_in_ready_in_done", d), 64'(ir[d]), 64'd0);
            end
        end
    end

    initial begin
        longint     t;
        longint     tp;
        logic [7:0] rs;
        logic [7:0] rc;
        vec_t b2b [6] = '{
            '{8'h01, 8'h01, 10'd3},
            '{8'h08, 8'h08, 10'd24},
            '{8'h06, 8'h03, 10'd12},
            '{8'h0F, 8'h00, 10'd15},
            '{8'h00, 8'h0F, 10'd30},
            '{8'h07, 8'h07, 10'd21}
        };

        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
            s_in[d] = '0;
            c_in[d] = '0;
        end

        // Reset state.
        rst_n = 1'b0;
        #(P + 2);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_reset_in_ready", d),  64'(ir[d]),   64'd1);
            check($sformatf("dut%0d_reset_out_valid", d), 64'(ov[d]),   64'd0);
            check($sformatf("dut%0d_reset_sum", d),       64'(sumw[d]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // CSA output for 1101+0001+1000, then maximum operands.
        send(0, 8'h04, 8'h09, 10'd22, t);
        wait_idle(0);
        send(0, 8'h0F, 8'h0F, 10'd45, t);
        wait_idle(0);

        // Backpressure: result held for well over 10 cycles, then released.
        ordy[0] = 1'b0;
        send(0, 8'h03, 8'h02, 10'd7, t);
        repeat (16) @(negedge clk);
        check("bp_out_valid_held", 64'(ov[0]),   64'd1);
        check("bp_in_ready_low",   64'(ir[0]),   64'd0);
        check("bp_sum_held",       64'(sumw[0]), 64'd7);
        ordy[0] = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 64'(ov[0]), 64'd0);
        check("bp_release_in_ready",  64'(ir[0]), 64'd1);

        // Reset while BUSY at k=2: the partial result is discarded.
        send(0, 8'h05, 8'h03, 10'd11, t);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(ov[0]),   64'd0);
        check("rst_mid_in_ready",  64'(ir[0]),   64'd1);
        check("rst_mid_sum",       64'(sumw[0]), 64'd0);
        q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h00, 8'h00, 10'd0, t);
        wait_idle(0);

        // in_valid with other data while BUSY and DONE is ignored.
        ordy[0] = 1'b0;
        send(0, 8'h0A, 8'h05, 10'd20, t);
        @(negedge clk);
        iv[0]   = 1'b1;
        s_in[0] = 8'h0F;
        c_in[0] = 8'h0F;
        repeat (8) @(negedge clk);
        check("ignore_in_done_out_valid", 64'(ov[0]), 64'd1);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        wait_idle(0);
        repeat (8) @(negedge clk);
        check("ignore_no_extra_output", 64'(ov[0]), 64'd0);

        // Back-to-back pairs: one accept every NCHK+2 cycles.
        for (int i = 0; i < 6; i++) begin
            send(0, b2b[i].s, b2b[i].c, b2b[i].e, t);
            if (i > 0) check("dut0_b2b_period", 64'(t - tp), 64'((NCHK_TAB[0] + 2) * P));
            tp = t;
        end
        wait_idle(0);

        // W=8, CHUNK=3: maximum operands, then random pairs back-to-back.
        send(1, 8'hFF, 8'hFF, 10'd765, t);
        wait_idle(1);
        for (int i = 0; i < 6; i++) begin
            rs = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            send(1, rs, rc, 10'(rs) + (10'(rc) << 1), t);
            if (i > 0) check("dut1_b2b_period", 64'(t - tp), 64'((NCHK_TAB[1] + 2) * P));
            tp = t;
        end
        wait_idle(1);

        // W=4, CHUNK=3: partial top chunk carries into sum[W+1].
        send(2, 8'h0F, 8'h0F, 10'd45, t);
        wait_idle(2);
        send(2, 8'h04, 8'h09, 10'd22, t);
        wait_idle(2);
        for (int i = 0; i < 4; i++) begin
            rs = 8'($urandom_range(0, 15));
            rc = 8'($urandom_range(0, 15));
            send(2, rs, rc, 10'(rs) + (10'(rc) << 1), t);
        end
        wait_idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
